// File: rtl/noise_gate_pkg.sv
// Shared types and constants for the per-channel noise gate.
// State encoding and gain format (unsigned, 256 = unity).
package noise_gate_pkg;

    typedef enum logic [2:0] {
        CLOSED,
        ATTACK,
        OPEN,
        HOLD,
        RELEASE
    } gate_state_e;

    localparam int GAIN_BITS = 8;
    localparam int GAIN_W = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

endpackage

// File: rtl/gate_gain_mult.sv
// Registered signed sample x unsigned gain, floor-shifted by GAIN_BITS.
// Holds the gate's only data-path register, so latency is one clk.
module gate_gain_mult
    import noise_gate_pkg::*;
#(
    parameter int RESOLUTION = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RESOLUTION-1:0] data_i,
    input  logic [GAIN_W-1:0]     gain_i,
    output logic [RESOLUTION-1:0] data_o
);

    localparam int PW = RESOLUTION + GAIN_W + 1;

    logic signed [PW-1:0] sample_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod;
    logic [RESOLUTION-1:0] data_d;
    logic [RESOLUTION-1:0] data_q;

    assign sample_ext = {{(GAIN_W + 1){data_i[RESOLUTION-1]}}, data_i};
    assign gain_ext   = {{(RESOLUTION + 1){1'b0}}, gain_i};
    assign prod       = sample_ext * gain_ext;

    // Slicing above the fraction bits is the floor shift plus truncation.
    assign data_d = prod[RESOLUTION+GAIN_BITS-1:GAIN_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/noise_gate.sv
// Per-channel noise gate: hysteresis, hold timer, attack/release gain ramp.
// Define NOISE_GATE_PEAK_EN to add the peak_clr / peak_level meter.
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter int                    RESOLUTION   = 32,
    parameter logic [RESOLUTION-1:0] THRESH_OPEN  = 'h0100_0000,
    parameter logic [RESOLUTION-1:0] THRESH_CLOSE = 'h0080_0000,
    parameter int                    HOLD_SAMPLES = 256,
    parameter int                    ATTACK_STEP  = 64,
    parameter int                    RELEASE_STEP = 8
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef NOISE_GATE_PEAK_EN
    input  logic                  peak_clr,
    output logic [RESOLUTION-2:0] peak_level,
`endif
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] data_in,
    output logic [RESOLUTION-1:0] data_out,
    output logic                  gate_open,
    output logic [GAIN_W-1:0]     gain_mon
);

    localparam int CNT_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_SAMPLES - 1);

    gate_state_e state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [RESOLUTION-1:0] neg;
    logic [RESOLUTION-2:0] level;
    logic                  above_open;
    logic                  above_close;
    logic [GAIN_W:0]       attack_sum;
    logic [GAIN_W-1:0]     attack_gain;
    logic [GAIN_W-1:0]     release_gain;
    logic [GAIN_W-1:0]     mult_gain;

    // Only the most-negative input keeps its sign bit after negation.
    assign neg = ~data_in + 1'b1;

    always_comb begin
        level = data_in[RESOLUTION-2:0];
        if (data_in[RESOLUTION-1]) begin
            level = neg[RESOLUTION-1] ? {(RESOLUTION - 1){1'b1}}
                                      : neg[RESOLUTION-2:0];
        end
    end

    assign above_open  = {1'b0, level} >= THRESH_OPEN;
    assign above_close = {1'b0, level} >= THRESH_CLOSE;

    assign attack_sum  = {1'b0, gain_q} + (GAIN_W + 1)'(ATTACK_STEP);
    assign attack_gain = (attack_sum >= {1'b0, GAIN_UNITY})
                         ? GAIN_UNITY : attack_sum[GAIN_W-1:0];

    assign release_gain = (gain_q <= GAIN_W'(RELEASE_STEP))
                          ? '0 : gain_q - GAIN_W'(RELEASE_STEP);

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = OPEN;
            gain_d  = GAIN_UNITY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                CLOSED: begin
                    gain_d = '0;
                    if (above_open) state_d = ATTACK;
                end
                ATTACK: begin
                    gain_d = attack_gain;
                    if (attack_gain == GAIN_UNITY) state_d = OPEN;
                end
                OPEN: begin
                    gain_d = GAIN_UNITY;
                    if (!above_close) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    gain_d = GAIN_UNITY;
                    if (above_close) begin
                        state_d = OPEN;
                    end else if (cnt_q == '0) begin
                        state_d = RELEASE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RELEASE: begin
                    // Reopening wins over this cycle's decrement.
                    if (above_open) begin
                        state_d = ATTACK;
                    end else begin
                        gain_d = release_gain;
                        if (release_gain == '0) state_d = CLOSED;
                    end
                end
                default: begin
                    state_d = CLOSED;
                    gain_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLOSED;
            gain_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bypass multiplies by unity so data_out keeps the same latency.
    assign mult_gain = enable ? gain_q : GAIN_UNITY;

    gate_gain_mult #(
        .RESOLUTION(RESOLUTION)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .data_i(data_in),
        .gain_i(mult_gain),
        .data_o(data_out)
    );

    assign gate_open = (state_q != CLOSED);
    assign gain_mon  = gain_q;

`ifdef NOISE_GATE_PEAK_EN
    logic [RESOLUTION-2:0] peak_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else if (peak_clr || (level > peak_q)) begin
            peak_q <= level;
        end
    end

    assign peak_level = peak_q;
`else
    // Peak meter not built in this configuration.
`endif

endmodule
